// File: rtl/priority_encoder8to3_if.sv
// ---------------------------------------------------------------------------
// priority_encoder8to3_if
// Bundles the request lines, the valid/ready code output and the status
// outputs of the sequential 8-to-3 priority encoder.
//   req_in    [7:0] : event pulses toward the encoder
//   out_valid       : output slot holds an unserved event
//   out_code  [2:0] : binary index of the offered event
//   out_ready       : consumer accepts the code on valid && ready
//   pending   [7:0] : latched events not yet moved into the slot
//   busy            : any pending event or a valid slot
// Modports:
//   master : the environment (drives requests and ready)
//   slave  : the encoder
// ---------------------------------------------------------------------------
interface priority_encoder8to3_if;
    logic [7:0] req_in;
    logic       out_valid;
    logic [2:0] out_code;
    logic       out_ready;
    logic [7:0] pending;
    logic       busy;

    modport master (
        output req_in,
        output out_ready,
        input  out_valid,
        input  out_code,
        input  pending,
        input  busy
    );

    modport slave (
        input  req_in,
        input  out_ready,
        output out_valid,
        output out_code,
        output pending,
        output busy
    );
endinterface

// File: rtl/priority_encoder8to3.sv
// ---------------------------------------------------------------------------
// priority_encoder8to3
// Sequential 8-to-3 priority encoder. Event pulses on req_in are latched in a
// pending vector and served one at a time through a registered valid/ready
// output slot, highest priority first.
// Parameters:
//   MSB_PRIORITY : 1 -> bit 7 wins, 0 -> bit 0 wins
// Ports:
//   clk  : clock, all state updates on the rising edge
//   rst  : synchronous active-high reset
//   bus  : priority_encoder8to3_if.slave (req_in, out_ready in;
//          out_valid, out_code, pending, busy out)
// ---------------------------------------------------------------------------
module priority_encoder8to3 #(
    parameter bit MSB_PRIORITY = 1'b1
) (
    input  logic                         clk,
    input  logic                         rst,
    priority_encoder8to3_if.slave        bus
);

    logic [7:0] r_pending;
    logic       r_out_valid;
    logic [2:0] r_out_code;

    logic [7:0] w_cand;
    logic       w_load;
    logic       w_hit;
    logic [2:0] w_sel;
    logic [7:0] w_sel_onehot;

    // Everything that could be served this edge: old events plus new pulses.
    assign w_cand = r_pending | bus.req_in;
    // Slot may take a new code when empty or being accepted right now,
    // which gives back-to-back acceptance without a bubble.
    assign w_load = !r_out_valid || bus.out_ready;
    assign w_hit  = |w_cand;

    // Priority pick: the loop direction makes the winning bit the last one
    // assigned, so no explicit break is needed.
    always_comb begin
        w_sel = 3'd0;
        if (MSB_PRIORITY) begin
            for (int i = 0; i < 8; i++) begin
                if (w_cand[i]) w_sel = 3'(i);
            end
        end else begin
            for (int i = 7; i >= 0; i--) begin
                if (w_cand[i]) w_sel = 3'(i);
            end
        end
    end

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_onehot
            assign w_sel_onehot[gi] = (w_sel == 3'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pending   <= 8'd0;
            r_out_valid <= 1'b0;
            r_out_code  <= 3'd0;
        end else if (w_load) begin
            if (w_hit) begin
                r_out_code  <= w_sel;
                r_out_valid <= 1'b1;
                // Only the served bit leaves; a re-request of the code that
                // was just in the slot stays as a fresh pending event.
                r_pending   <= w_cand & ~w_sel_onehot;
            end else begin
                r_out_valid <= 1'b0;
                r_pending   <= 8'd0;
            end
        end else begin
            // Stalled: slot frozen, new pulses merge into pending.
            r_pending <= w_cand;
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.out_code  = r_out_code;
    assign bus.pending   = r_pending;
    assign bus.busy      = (|r_pending) | r_out_valid;

endmodule

// File: tb/tb_priority_encoder8to3.sv
// ---------------------------------------------------------------------------
// tb_priority_encoder8to3
// Directed test of the sequential priority encoder. Two instances run side by
// side on the same stimulus: one with MSB priority, one with LSB priority.
// Inputs change 1 ns after a rising edge; outputs are checked at that point.
// ---------------------------------------------------------------------------
module tb_priority_encoder8to3;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    priority_encoder8to3_if m_if ();
    priority_encoder8to3_if l_if ();

    priority_encoder8to3 #(.MSB_PRIORITY(1'b1)) u_msb (
        .clk (clk),
        .rst (rst),
        .bus (m_if.slave)
    );

    priority_encoder8to3 #(.MSB_PRIORITY(1'b0)) u_lsb (
        .clk (clk),
        .rst (rst),
        .bus (l_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [7:0] req, input logic rdy);
        m_if.req_in    = req;
        l_if.req_in    = req;
        m_if.out_ready = rdy;
        l_if.out_ready = rdy;
    endtask

    function automatic logic [7:0] dec3to8(input logic [2:0] c);
        logic [7:0] one;
        one = 8'd1;
        return one << c;
    endfunction

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        drive(8'h00, 1'b1);
        tick();
        tick();
        check("rst_valid",   32'(m_if.out_valid), 32'd0);
        check("rst_pending", 32'(m_if.pending),   32'h00);
        check("rst_code",    32'(m_if.out_code),  32'd0);
        check("rst_busy",    32'(m_if.busy),      32'd0);
        rst = 1'b0;

        // single request
        drive(8'h20, 1'b1);
        tick();
        check("single_valid", 32'(m_if.out_valid), 32'd1);
        check("single_code",  32'(m_if.out_code),  32'd5);
        check("single_code_l",32'(l_if.out_code),  32'd5);
        drive(8'h00, 1'b1);
        tick();
        check("single_done_valid", 32'(m_if.out_valid), 32'd0);
        check("single_done_busy",  32'(m_if.busy),      32'd0);

        // simultaneous requests, both priority orders
        drive(8'h81, 1'b1);
        tick();
        check("simul_m_code0", 32'(m_if.out_code), 32'd7);
        check("simul_l_code0", 32'(l_if.out_code), 32'd0);
        check("simul_m_pend",  32'(m_if.pending),  32'h01);
        check("simul_l_pend",  32'(l_if.pending),  32'h80);
        drive(8'h00, 1'b1);
        tick();
        check("simul_m_code1", 32'(m_if.out_code),  32'd0);
        check("simul_l_code1", 32'(l_if.out_code),  32'd7);
        check("simul_m_valid1",32'(m_if.out_valid), 32'd1);
        tick();
        check("simul_m_end", 32'(m_if.out_valid), 32'd0);
        check("simul_l_end", 32'(l_if.out_valid), 32'd0);

        // backpressure
        drive(8'h0C, 1'b0);
        tick();
        check("bp_l_code", 32'(l_if.out_code), 32'd2);
        check("bp_l_pend", 32'(l_if.pending),  32'h08);
        drive(8'h00, 1'b0);
        for (int k = 0; k < 4; k++) begin
            check("bp_m_code", 32'(m_if.out_code),  32'd3);
            check("bp_m_valid",32'(m_if.out_valid), 32'd1);
            check("bp_m_pend", 32'(m_if.pending),   32'h04);
            if (k < 3) tick();
        end
        drive(8'h00, 1'b1);
        tick();
        check("bp_rel_m_code", 32'(m_if.out_code), 32'd2);
        check("bp_rel_m_pend", 32'(m_if.pending),  32'h00);
        check("bp_rel_l_code", 32'(l_if.out_code), 32'd3);
        tick();
        check("bp_end_valid", 32'(m_if.out_valid), 32'd0);

        // pre-emption and re-request of the slot's own bit
        drive(8'h04, 1'b0);
        tick();
        check("pre_slot", 32'(m_if.out_code), 32'd2);
        drive(8'h44, 1'b0);
        tick();
        check("pre_m_pend", 32'(m_if.pending),  32'h44);
        check("pre_m_hold", 32'(m_if.out_code), 32'd2);
        check("pre_l_pend", 32'(l_if.pending),  32'h44);
        drive(8'h00, 1'b1);
        tick();
        check("pre_m_c1", 32'(m_if.out_code), 32'd6);
        check("pre_l_c1", 32'(l_if.out_code), 32'd2);
        check("pre_m_p1", 32'(m_if.pending),  32'h04);
        tick();
        check("pre_m_c2", 32'(m_if.out_code),  32'd2);
        check("pre_l_c2", 32'(l_if.out_code),  32'd6);
        check("pre_m_v2", 32'(m_if.out_valid), 32'd1);
        tick();
        check("pre_end", 32'(m_if.out_valid), 32'd0);

        // reset mid-burst
        drive(8'hFF, 1'b0);
        tick();
        check("rb_m_code", 32'(m_if.out_code), 32'd7);
        check("rb_m_pend", 32'(m_if.pending),  32'h7F);
        drive(8'h80, 1'b0);
        tick();
        check("rb_m_full", 32'(m_if.pending),   32'hFF);
        check("rb_m_val",  32'(m_if.out_valid), 32'd1);
        check("rb_l_pend", 32'(l_if.pending),   32'hFE);
        rst = 1'b1;
        drive(8'h01, 1'b0);
        tick();
        check("rb_valid", 32'(m_if.out_valid), 32'd0);
        check("rb_pend",  32'(m_if.pending),   32'h00);
        check("rb_code",  32'(m_if.out_code),  32'd0);
        check("rb_l_pend",32'(l_if.pending),   32'h00);
        rst = 1'b0;
        drive(8'h00, 1'b1);
        tick();
        check("rb_after", 32'(m_if.out_valid), 32'd0);

        // every one-hot value through a 3-to-8 decoder model
        for (int k = 0; k < 8; k++) begin
            logic [7:0] oh;
            oh = 8'd1 << k;
            drive(oh, 1'b1);
            tick();
            check("oh_m_valid", 32'(m_if.out_valid),         32'd1);
            check("oh_m_dec",   32'(dec3to8(m_if.out_code)), 32'(oh));
            check("oh_l_dec",   32'(dec3to8(l_if.out_code)), 32'(oh));
            drive(8'h00, 1'b1);
            tick();
            check("oh_idle", 32'(m_if.out_valid), 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
